// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 encodings,
// FSM states, latched-op payload and access-size helpers.
package lsu_pkg;

    localparam int unsigned MEM_BYTES_DEF = 1024;
    localparam int unsigned XLEN          = 32;
    localparam int unsigned OP_W          = 3;
    localparam int unsigned RD_W          = 5;

    localparam logic [OP_W-1:0] LD_LB  = 3'b000;
    localparam logic [OP_W-1:0] LD_LH  = 3'b001;
    localparam logic [OP_W-1:0] LD_LW  = 3'b010;
    localparam logic [OP_W-1:0] LD_LBU = 3'b100;
    localparam logic [OP_W-1:0] LD_LHU = 3'b101;

    // Store encodings double as the memory's write-type code.
    localparam logic [OP_W-1:0] ST_SB  = 3'b000;
    localparam logic [OP_W-1:0] ST_SH  = 3'b001;
    localparam logic [OP_W-1:0] ST_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic            is_store;
        logic [OP_W-1:0] op;
        logic [RD_W-1:0] rd;
    } lsu_op_t;

    // Access width in bytes; op[2] only selects signedness for loads.
    function automatic logic [2:0] access_size(input logic [OP_W-1:0] op);
        case (op[1:0])
            2'b00:   access_size = 3'd1;
            2'b01:   access_size = 3'd2;
            default: access_size = 3'd4;
        endcase
    endfunction

    function automatic logic op_legal(input logic is_store, input logic [OP_W-1:0] op);
        if (is_store) begin
            op_legal = (op == ST_SB) || (op == ST_SH) || (op == ST_SW);
        end else begin
            op_legal = (op == LD_LB) || (op == LD_LH) || (op == LD_LW) ||
                       (op == LD_LBU) || (op == LD_LHU);
        end
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Extracts the low byte/halfword/word of a returned memory word and
// sign- or zero-extends it according to the load funct3.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] word_i,
    input  logic [OP_W-1:0] op_i,
    output logic [XLEN-1:0] data_o
);

    always_comb begin
        data_o = '0;
        case (op_i)
            LD_LB:   data_o = {{24{word_i[7]}}, word_i[7:0]};
            LD_LH:   data_o = {{16{word_i[15]}}, word_i[15:0]};
            LD_LW:   data_o = word_i;
            LD_LBU:  data_o = {24'd0, word_i[7:0]};
            LD_LHU:  data_o = {16'd0, word_i[15:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: accepts one load/store, checks legality, pulses a one-cycle
// memory request, extends load data and hands the result to writeback.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = MEM_BYTES_DEF,
    parameter int unsigned CHECK_ALIGN = 1
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_store,
    input  logic [OP_W-1:0] in_op,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [RD_W-1:0] in_rd,

    output logic            mem_read_req,
    output logic [XLEN-1:0] mem_read_addr,
    input  logic [XLEN-1:0] mem_read_data,
    output logic            mem_write_req,
    output logic [XLEN-1:0] mem_write_addr,
    output logic [XLEN-1:0] mem_write_data,
    output logic [OP_W-1:0] mem_write_type,

    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_is_load,
    output logic [RD_W-1:0] out_rd,
    output logic [XLEN-1:0] out_data,
    output logic            out_fault
);

    lsu_state_e      state_q, state_d;
    lsu_op_t         op_q, op_d;
    logic            rd_req_q, rd_req_d;
    logic [XLEN-1:0] rd_addr_q, rd_addr_d;
    logic            wr_req_q, wr_req_d;
    logic [XLEN-1:0] wr_addr_q, wr_addr_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic [OP_W-1:0] wr_type_q, wr_type_d;
    logic            ov_q, ov_d;
    logic            ol_q, ol_d;
    logic [RD_W-1:0] ord_q, ord_d;
    logic [XLEN-1:0] odata_q, odata_d;
    logic            ofault_q, ofault_d;

    logic [2:0]      size_c;
    logic [32:0]     last_byte_c;
    logic            range_fault_c;
    logic            align_fault_c;
    logic            fault_c;
    logic [XLEN-1:0] ext_c;

    // 33-bit sum so an access wrapping past 0xFFFFFFFF still counts as out of range.
    assign size_c        = access_size(in_op);
    assign last_byte_c   = 33'(in_addr) + 33'(size_c) - 33'd1;
    assign range_fault_c = last_byte_c > (33'(MEM_BYTES) - 33'd1);
    assign align_fault_c = (CHECK_ALIGN != 0) &&
                           (((size_c == 3'd2) && in_addr[0]) ||
                            ((size_c == 3'd4) && (in_addr[1:0] != 2'b00)));
    assign fault_c       = !op_legal(in_is_store, in_op) || range_fault_c || align_fault_c;

    lsu_load_extend u_extend (
        .word_i (mem_read_data),
        .op_i   (op_q.op),
        .data_o (ext_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_type_q <= '0;
            ov_q      <= 1'b0;
            ol_q      <= 1'b0;
            ord_q     <= '0;
            odata_q   <= '0;
            ofault_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_req_q  <= rd_req_d;
            rd_addr_q <= rd_addr_d;
            wr_req_q  <= wr_req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_type_q <= wr_type_d;
            ov_q      <= ov_d;
            ol_q      <= ol_d;
            ord_q     <= ord_d;
            odata_q   <= odata_d;
            ofault_q  <= ofault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_req_d  = rd_req_q;
        rd_addr_d = rd_addr_q;
        wr_req_d  = wr_req_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_type_d = wr_type_q;
        ov_d      = ov_q;
        ol_d      = ol_q;
        ord_d     = ord_q;
        odata_d   = odata_q;
        ofault_d  = ofault_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d = '{is_store: in_is_store, op: in_op, rd: in_rd};
                    if (fault_c) begin
                        state_d  = S_RESP;
                        ov_d     = 1'b1;
                        ofault_d = 1'b1;
                        ol_d     = !in_is_store;
                        ord_d    = in_is_store ? '0 : in_rd;
                        odata_d  = '0;
                    end else begin
                        state_d = S_REQ;
                        if (in_is_store) begin
                            wr_req_d  = 1'b1;
                            wr_addr_d = in_addr;
                            wr_data_d = in_wdata;
                            wr_type_d = in_op;
                        end else begin
                            rd_req_d  = 1'b1;
                            rd_addr_d = in_addr;
                        end
                    end
                end
            end
            S_REQ: begin
                state_d  = S_RESP;
                rd_req_d = 1'b0;
                wr_req_d = 1'b0;
                ov_d     = 1'b1;
                ofault_d = 1'b0;
                ol_d     = !op_q.is_store;
                ord_d    = op_q.is_store ? '0 : op_q.rd;
                odata_d  = op_q.is_store ? '0 : ext_c;
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    ov_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready       = (state_q == S_IDLE);
    assign mem_read_req   = rd_req_q;
    assign mem_read_addr  = rd_addr_q;
    assign mem_write_req  = wr_req_q;
    assign mem_write_addr = wr_addr_q;
    assign mem_write_data = wr_data_q;
    assign mem_write_type = wr_type_q;
    assign out_valid      = ov_q;
    assign out_is_load    = ol_q;
    assign out_rd         = ord_q;
    assign out_data       = odata_q;
    assign out_fault      = ofault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 1 KiB little-endian byte memory
// that acts on the rising edge of each request line.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_store;
    logic [2:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        mem_read_req;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_read_data;
    logic        mem_write_req;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic [2:0]  mem_write_type;
    logic        out_valid;
    logic        out_ready;
    logic        out_is_load;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_fault;

    logic [7:0]  mem [0:1023];
    logic [9:0]  ra, wa;
    int          rd_pulses = 0;
    int          wr_pulses = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    load_store_unit dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_is_store    (in_is_store),
        .in_op          (in_op),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_rd          (in_rd),
        .mem_read_req   (mem_read_req),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data),
        .mem_write_req  (mem_write_req),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_write_type (mem_write_type),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_is_load    (out_is_load),
        .out_rd         (out_rd),
        .out_data       (out_data),
        .out_fault      (out_fault)
    );

    // Memory samples address/data just after the request edge.
    always @(posedge mem_read_req) begin
        rd_pulses++;
        #1;
        ra = mem_read_addr[9:0];
        mem_read_data = {mem[ra + 10'd3], mem[ra + 10'd2], mem[ra + 10'd1], mem[ra]};
    end

    always @(posedge mem_write_req) begin
        wr_pulses++;
        #1;
        wa = mem_write_addr[9:0];
        mem[wa] = mem_write_data[7:0];
        if (mem_write_type != 3'b000) mem[wa + 10'd1] = mem_write_data[15:8];
        if (mem_write_type == 3'b010) begin
            mem[wa + 10'd2] = mem_write_data[23:16];
            mem[wa + 10'd3] = mem_write_data[31:24];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full transaction with out_ready=1; called 1 time unit after a rising edge.
    task automatic do_op(input string tag, input logic st, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic flt, input logic [31:0] exp);
        int rp0, wp0;
        rp0 = rd_pulses;
        wp0 = wr_pulses;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_is_store = st; in_op = op;
        in_addr = addr; in_wdata = wdata; in_rd = rd;
        @(posedge clock); #1;
        in_valid = 1'b0;
        if (flt) begin
            chk({tag, ".f_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".f_fault"}, 32'(out_fault), 32'd1);
            chk({tag, ".f_data"}, out_data, 32'd0);
            chk({tag, ".f_rd"}, 32'(out_rd), st ? 32'd0 : 32'(rd));
            chk({tag, ".f_noreq"}, 32'(mem_read_req | mem_write_req), 32'd0);
        end else begin
            chk({tag, ".req_valid"}, 32'(out_valid), 32'd0);
            if (st) begin
                chk({tag, ".wreq"}, 32'(mem_write_req), 32'd1);
                chk({tag, ".waddr"}, mem_write_addr, addr);
                chk({tag, ".wtype"}, 32'(mem_write_type), 32'(op));
                chk({tag, ".wdata"}, mem_write_data, wdata);
            end else begin
                chk({tag, ".rreq"}, 32'(mem_read_req), 32'd1);
                chk({tag, ".raddr"}, mem_read_addr, addr);
            end
            @(posedge clock); #1;
            chk({tag, ".req_drop"}, 32'(mem_read_req | mem_write_req), 32'd0);
            chk({tag, ".valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".fault"}, 32'(out_fault), 32'd0);
            chk({tag, ".data"}, out_data, exp);
            chk({tag, ".rd"}, 32'(out_rd), st ? 32'd0 : 32'(rd));
        end
        chk({tag, ".is_load"}, 32'(out_is_load), st ? 32'd0 : 32'd1);
        chk({tag, ".rd_pulses"}, 32'(rd_pulses - rp0), (!flt && !st) ? 32'd1 : 32'd0);
        chk({tag, ".wr_pulses"}, 32'(wr_pulses - wp0), (!flt && st) ? 32'd1 : 32'd0);
        @(posedge clock); #1;
        chk({tag, ".done_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem_read_data = '0;
        reset = 1'b1; in_valid = 1'b0; in_is_store = 1'b0; in_op = 3'b000;
        in_addr = '0; in_wdata = '0; in_rd = '0; out_ready = 1'b1;
        #3;
        chk("rst.rreq", 32'(mem_read_req), 32'd0);
        chk("rst.wreq", 32'(mem_write_req), 32'd0);
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.data", out_data, 32'd0);
        #9 reset = 1'b0;
        @(posedge clock); #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        do_op("sw10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 32'd0);
        do_op("lb13",  1'b0, 3'b000, 32'h13, 32'd0, 5'd5, 1'b0, 32'hFFFFFFDE);
        do_op("lbu13", 1'b0, 3'b100, 32'h13, 32'd0, 5'd6, 1'b0, 32'h000000DE);
        do_op("lh12",  1'b0, 3'b001, 32'h12, 32'd0, 5'd7, 1'b0, 32'hFFFFDEAD);
        do_op("lhu10", 1'b0, 3'b101, 32'h10, 32'd0, 5'd8, 1'b0, 32'h0000BEEF);
        do_op("lw10",  1'b0, 3'b010, 32'h10, 32'd0, 5'd9, 1'b0, 32'hDEADBEEF);

        do_op("f_lw11",  1'b0, 3'b010, 32'h11,  32'd0, 5'd3, 1'b1, 32'd0);
        do_op("f_sh15",  1'b1, 3'b001, 32'h15,  32'h1234, 5'd0, 1'b1, 32'd0);
        do_op("f_sw3fe", 1'b1, 3'b010, 32'h3FE, 32'h55667788, 5'd0, 1'b1, 32'd0);
        do_op("f_lb400", 1'b0, 3'b000, 32'h400, 32'd0, 5'd4, 1'b1, 32'd0);
        do_op("f_ld011", 1'b0, 3'b011, 32'h10,  32'd0, 5'd2, 1'b1, 32'd0);
        do_op("f_st011", 1'b1, 3'b011, 32'h10,  32'd0, 5'd0, 1'b1, 32'd0);
        do_op("f_lbmax", 1'b0, 3'b000, 32'hFFFFFFFF, 32'd0, 5'd1, 1'b1, 32'd0);
        chk("f_sw3fe.mem", 32'(mem[10'h3FE]), 32'd0);

        do_op("sw3fc", 1'b1, 3'b010, 32'h3FC, 32'h12345678, 5'd0, 1'b0, 32'd0);
        do_op("lw3fc", 1'b0, 3'b010, 32'h3FC, 32'd0, 5'd10, 1'b0, 32'h12345678);
        do_op("lh3fe", 1'b0, 3'b001, 32'h3FE, 32'd0, 5'd11, 1'b0, 32'h00001234);
        do_op("lb3ff", 1'b0, 3'b000, 32'h3FF, 32'd0, 5'd12, 1'b0, 32'h00000012);

        // Backpressure: result held while a second op waits unaccepted.
        out_ready = 1'b0;
        in_valid = 1'b1; in_is_store = 1'b0; in_op = 3'b010; in_addr = 32'h10; in_rd = 5'd13;
        @(posedge clock); #1;
        in_is_store = 1'b1; in_op = 3'b000; in_addr = 32'h30; in_wdata = 32'h55; in_rd = 5'd0;
        @(posedge clock); #1;
        for (int c = 0; c < 4; c++) begin
            chk("bp.valid", 32'(out_valid), 32'd1);
            chk("bp.data", out_data, 32'hDEADBEEF);
            chk("bp.rd", 32'(out_rd), 32'd13);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            chk("bp.noreq", 32'(mem_read_req | mem_write_req), 32'd0);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp.valid_last", 32'(out_valid), 32'd1);
        @(posedge clock); #1;
        chk("bp.released", 32'(out_valid), 32'd0);
        chk("bp.in_ready2", 32'(in_ready), 32'd1);
        chk("bp.no_write", 32'(mem[10'h30]), 32'd0);

        // Asynchronous reset in the middle of a load's request cycle.
        in_valid = 1'b1; in_is_store = 1'b0; in_op = 3'b010; in_addr = 32'h10; in_rd = 5'd14;
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("ar.rreq", 32'(mem_read_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar.rreq_drop", 32'(mem_read_req), 32'd0);
        chk("ar.valid", 32'(out_valid), 32'd0);
        #2 reset = 1'b0;
        @(posedge clock); #1;
        chk("ar.in_ready", 32'(in_ready), 32'd1);
        chk("ar.no_resp", 32'(out_valid), 32'd0);
        do_op("sb20", 1'b1, 3'b000, 32'h20, 32'h000000AB, 5'd0, 1'b0, 32'd0);
        chk("sb20.mem", 32'(mem[10'h20]), 32'hAB);
        chk("sb20.mem_next", 32'(mem[10'h21]), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
